// File: rtl/rv_arb_pkg.sv
// Shared types and constants for the RISC-V memory arbiter.
// Holds the FSM state encoding and the owner encoding used on the owner output.
package rv_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

endpackage

// File: rtl/rv_mem_arb_if.sv
// Bundle of requester-side (core, DMA) and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface rv_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output c_ack, d_ack, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  c_ack, d_ack, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/rv_arb_pick.sv
// Winner select for the arbiter: core priority, overridden once DMA has lost
// MAX_STV consecutive contested grants. Owns the starvation counter.
module rv_arb_pick
  import rv_arb_pkg::*;
#(
  parameter int MAX_STV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic d_req,
  input  logic grant,
  output logic winner
);
  localparam logic [3:0] STV_MAX = 4'(MAX_STV);

  logic [3:0] r_stv_cnt;
  logic       w_both;

  assign w_both = c_req & d_req;

  // NOTE: assign a default first so every path drives winner and no latch is inferred.
  always_comb begin
    winner = OWN_CORE;
    if (w_both)      winner = (r_stv_cnt == STV_MAX) ? OWN_DMA : OWN_CORE;
    else if (d_req)  winner = OWN_DMA;
  end

  // Counter only moves on an actual grant; withdrawn requests leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stv_cnt <= '0;
    end else if (grant) begin
      if (winner == OWN_DMA)                   r_stv_cnt <= '0;
      else if (w_both && r_stv_cnt != STV_MAX) r_stv_cnt <= r_stv_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/rv_mem_arb.sv
// Single-port memory arbiter between the multicycle core and the DMA/loader.
// Each transaction runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE (ack pulse).
module rv_mem_arb
  import rv_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int MAX_STV = 4
) (
  input  logic          clk,
  input  logic          rst,
  rv_mem_arb_if.slave   bus
);
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  arb_state_t    r_state;
  logic [3:0]    r_lat_cnt;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_c_ack;
  logic          r_d_ack;
  logic          w_grant;
  logic          w_winner;

  assign w_grant = (r_state == ARB_IDLE) && (bus.c_req || bus.d_req);

  rv_arb_pick #(.MAX_STV(MAX_STV)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .c_req  (bus.c_req),
    .d_req  (bus.d_req),
    .grant  (w_grant),
    .winner (w_winner)
  );

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_lat_cnt <= '0;
      r_owner   <= OWN_CORE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_c_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_winner;
            r_we      <= (w_winner == OWN_DMA) ? bus.d_we    : bus.c_we;
            r_addr    <= (w_winner == OWN_DMA) ? bus.d_addr  : bus.c_addr;
            r_wdata   <= (w_winner == OWN_DMA) ? bus.d_wdata : bus.c_wdata;
            r_mem_en  <= 1'b1;
            r_mem_we  <= (w_winner == OWN_DMA) ? bus.d_we    : bus.c_we;
            r_lat_cnt <= LAT_INIT;
            r_state   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (r_lat_cnt != 4'd0) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end else begin
            // Stores leave the last read value untouched.
            if (!r_we) r_rdata <= bus.mem_rdata;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_c_ack  <= (r_owner == OWN_CORE);
            r_d_ack  <= (r_owner == OWN_DMA);
            r_state  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_c_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.c_ack     = r_c_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != ARB_IDLE);
  assign bus.owner     = r_owner;
endmodule
